// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage controller.
// Holds opcodes, FSM state encoding, ALU codes, field positions and the registered control bundle.
package exec_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_LDI   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  localparam int RD_LSB = 9;
  localparam int RS_LSB = 6;
  localparam int IMM_W  = 6;

`ifdef EXEC_MFC_TIMEOUT_EN
  // Count value seen on the 15th consecutive MWAIT cycle without MFC.
  localparam logic [3:0] MFC_MISS_LIMIT = 4'd14;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECODE,
    S_ALU,
    S_WB,
    S_WB_IMM,
    S_MADDR,
    S_MREQ,
    S_MWAIT,
    S_MDATA,
    S_JUMP,
    S_PCINC,
    S_DONE,
    S_HALT
  } state_e;

  typedef struct packed {
    logic       regAout;
    logic       regBout;
    logic       aluEN;
    logic       regWrite;
    logic       immEN;
    logic       MARin;
    logic       memEN;
    logic       RW;
    logic       MDRreadEN;
    logic       MDRout;
    logic       MDRin;
    logic       PCinc;
    logic       PCload;
    logic       done;
    logic       busy;
    logic       halted;
    logic [2:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational opcode classifier used by exec_fsm.
module exec_decode
  import exec_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       isAlu_o,
  output logic       isMem_o,
  output logic       isLoad_o,
  output logic       isImm_o,
  output logic       isJump_o,
  output logic       isHalt_o,
  output logic       isIllegal_o,
  output logic [2:0] aluOp_o
);

  always_comb begin
    isAlu_o     = 1'b0;
    isMem_o     = 1'b0;
    isLoad_o    = 1'b0;
    isImm_o     = 1'b0;
    isJump_o    = 1'b0;
    isHalt_o    = 1'b0;
    isIllegal_o = 1'b0;
    aluOp_o     = ALU_PASS;
    case (op_i)
      OP_NOP:   ;
      OP_ADD:   begin isAlu_o = 1'b1; aluOp_o = ALU_ADD; end
      OP_SUB:   begin isAlu_o = 1'b1; aluOp_o = ALU_SUB; end
      OP_AND:   begin isAlu_o = 1'b1; aluOp_o = ALU_AND; end
      OP_OR:    begin isAlu_o = 1'b1; aluOp_o = ALU_OR;  end
      OP_LOAD:  begin isMem_o = 1'b1; isLoad_o = 1'b1; end
      OP_STORE: isMem_o  = 1'b1;
      OP_LDI:   isImm_o  = 1'b1;
      OP_JMP:   isJump_o = 1'b1;
      OP_HALT:  isHalt_o = 1'b1;
      default:  isIllegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_fsm.sv
// Execute-stage controller: latches the instruction from fetch and sequences register, memory and PC strobes.
// Optional EXEC_MFC_TIMEOUT_EN adds an MFC watchdog and the sticky memErr output.
module exec_fsm
  import exec_pkg::*;
#(
  parameter int DATAW = 16,
  parameter int REGAW = 3,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DATAW-1:0] ir,
  input  logic             MFC,
  output logic [REGAW-1:0] rdAddr,
  output logic [REGAW-1:0] rsAddr,
  output logic             regAout,
  output logic             regBout,
  output logic [2:0]       aluOp,
  output logic             aluEN,
  output logic             regWrite,
  output logic [DATAW-1:0] immOut,
  output logic             immEN,
  output logic             MARin,
  output logic             memEN,
  output logic             RW,
  output logic             MDRreadEN,
  output logic             MDRout,
  output logic             MDRin,
  output logic             PCinc,
  output logic             PCload,
  output logic             done,
  output logic             busy,
  output logic             halted,
`ifdef EXEC_MFC_TIMEOUT_EN
  output logic             memErr,
`endif
  output logic             illegal
);

  state_e           stateQ, stateD;
  logic [DATAW-1:0] irQ, irD;
  ctrl_t            ctrlQ, ctrlD;
  logic             illegalQ, illegalD;
`ifdef EXEC_MFC_TIMEOUT_EN
  logic [3:0]       cntQ, cntD;
  logic             memErrQ, memErrD;
`endif

  logic       isAlu, isMem, isLoad, isImm, isJump, isHalt, isIllegal;
  logic [2:0] decAluOp;

  exec_decode uDecode (
    .op_i        (irQ[DATAW-1 -: OPW]),
    .isAlu_o     (isAlu),
    .isMem_o     (isMem),
    .isLoad_o    (isLoad),
    .isImm_o     (isImm),
    .isJump_o    (isJump),
    .isHalt_o    (isHalt),
    .isIllegal_o (isIllegal),
    .aluOp_o     (decAluOp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= S_IDLE;
      irQ      <= '0;
      ctrlQ    <= '0;
      illegalQ <= 1'b0;
`ifdef EXEC_MFC_TIMEOUT_EN
      cntQ     <= '0;
      memErrQ  <= 1'b0;
`endif
    end else begin
      stateQ   <= stateD;
      irQ      <= irD;
      ctrlQ    <= ctrlD;
      illegalQ <= illegalD;
`ifdef EXEC_MFC_TIMEOUT_EN
      cntQ     <= cntD;
      memErrQ  <= memErrD;
`endif
    end
  end

  // Only IDLE accepts start, so the instruction register is frozen while busy.
  always_comb begin
    stateD   = stateQ;
    irD      = irQ;
    illegalD = illegalQ;
`ifdef EXEC_MFC_TIMEOUT_EN
    cntD     = cntQ;
    memErrD  = memErrQ;
`endif
    case (stateQ)
      S_IDLE: begin
        if (start) begin
          irD    = ir;
          stateD = S_DECODE;
        end
      end
      S_DECODE: begin
        if (isAlu)       stateD = S_ALU;
        else if (isMem)  stateD = S_MADDR;
        else if (isImm)  stateD = S_WB_IMM;
        else if (isJump) stateD = S_JUMP;
        else if (isHalt) stateD = S_HALT;
        else begin
          if (isIllegal) illegalD = 1'b1;
          stateD = S_PCINC;
        end
      end
      S_ALU:    stateD = S_WB;
      S_WB:     stateD = S_PCINC;
      S_WB_IMM: stateD = S_PCINC;
      S_MADDR:  stateD = S_MREQ;
      S_MREQ: begin
        stateD = S_MWAIT;
`ifdef EXEC_MFC_TIMEOUT_EN
        cntD   = '0;
`endif
      end
      S_MWAIT: begin
        if (MFC) begin
          stateD = isLoad ? S_MDATA : S_PCINC;
        end
`ifdef EXEC_MFC_TIMEOUT_EN
        else if (cntQ == MFC_MISS_LIMIT) begin
          memErrD = 1'b1;
          stateD  = S_PCINC;
        end else begin
          cntD = cntQ + 4'd1;
        end
`endif
      end
      S_MDATA:  stateD = S_PCINC;
      S_JUMP:   stateD = S_DONE;
      S_PCINC:  stateD = S_DONE;
      S_DONE:   stateD = S_IDLE;
      S_HALT:   stateD = S_HALT;
      default:  stateD = S_IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so every output leaves a flop.
  always_comb begin
    ctrlD = '0;
    case (stateD)
      S_ALU: begin
        ctrlD.regAout = 1'b1;
        ctrlD.regBout = 1'b1;
        ctrlD.aluEN   = 1'b1;
        ctrlD.aluOp   = decAluOp;
      end
      S_WB:     ctrlD.regWrite = 1'b1;
      S_WB_IMM: begin
        ctrlD.immEN    = 1'b1;
        ctrlD.regWrite = 1'b1;
      end
      S_MADDR: begin
        ctrlD.regAout = 1'b1;
        ctrlD.MARin   = 1'b1;
      end
      S_MREQ: begin
        ctrlD.memEN   = 1'b1;
        ctrlD.RW      = isLoad;
        ctrlD.regBout = ~isLoad;
        ctrlD.MDRin   = ~isLoad;
      end
      S_MWAIT: begin
        ctrlD.memEN = 1'b1;
        ctrlD.RW    = isLoad;
      end
      S_MDATA: begin
        ctrlD.MDRreadEN = 1'b1;
        ctrlD.MDRout    = 1'b1;
        ctrlD.regWrite  = 1'b1;
      end
      S_JUMP: begin
        ctrlD.immEN  = 1'b1;
        ctrlD.PCload = 1'b1;
      end
      S_PCINC:  ctrlD.PCinc = 1'b1;
      S_DONE:   ctrlD.done  = 1'b1;
      default:  ;
    endcase
    ctrlD.busy   = (stateD != S_IDLE) && (stateD != S_HALT);
    ctrlD.halted = (stateD == S_HALT);
  end

  assign rdAddr    = irQ[RD_LSB +: REGAW];
  assign rsAddr    = irQ[RS_LSB +: REGAW];
  assign immOut    = {{(DATAW-IMM_W){1'b0}}, irQ[IMM_W-1:0]};
  assign regAout   = ctrlQ.regAout;
  assign regBout   = ctrlQ.regBout;
  assign aluOp     = ctrlQ.aluOp;
  assign aluEN     = ctrlQ.aluEN;
  assign regWrite  = ctrlQ.regWrite;
  assign immEN     = ctrlQ.immEN;
  assign MARin     = ctrlQ.MARin;
  assign memEN     = ctrlQ.memEN;
  assign RW        = ctrlQ.RW;
  assign MDRreadEN = ctrlQ.MDRreadEN;
  assign MDRout    = ctrlQ.MDRout;
  assign MDRin     = ctrlQ.MDRin;
  assign PCinc     = ctrlQ.PCinc;
  assign PCload    = ctrlQ.PCload;
  assign done      = ctrlQ.done;
  assign busy      = ctrlQ.busy;
  assign halted    = ctrlQ.halted;
  assign illegal   = illegalQ;
`ifdef EXEC_MFC_TIMEOUT_EN
  assign memErr    = memErrQ;
`endif

endmodule

// File: tb/tb_exec_fsm.sv
// Self-checking bench for exec_fsm: directed scenarios plus randomized instructions against a cycle-count model.
module tb_exec_fsm;

  logic        clk = 1'b0;
  logic        rst, start, MFC;
  logic [15:0] ir;
  logic [2:0]  rdAddr, rsAddr, aluOp;
  logic [15:0] immOut;
  logic        regAout, regBout, aluEN, regWrite, immEN, MARin, memEN, RW;
  logic        MDRreadEN, MDRout, MDRin, PCinc, PCload, done, busy, halted, illegal;
`ifdef EXEC_MFC_TIMEOUT_EN
  logic        memErr;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit stickyIllegal = 1'b0;

  int oDone, oDoneCnt, oRegW, oRegWAt, oPcInc, oPcIncAt, oPcLoad, oMem, oRw;
  int oMar, oMarAt, oAlu, oAluAt, oRegA, oRegB, oMdrIn, oMdrInAt, oMdrOut, oMdrOutAt;
  int oMdrRd, oImm, oBusy, oFieldErr;
  logic [2:0] oAluOp;
  logic oEndBusy, oEndDone, oEndIllegal, oEndHalted, oEndMemErr;

  logic anyCore, anyOut;
  assign anyCore = |{rdAddr, rsAddr, regAout, regBout, aluOp, aluEN, regWrite, immOut, immEN,
                     MARin, memEN, RW, MDRreadEN, MDRout, MDRin, PCinc, PCload, done, busy,
                     halted, illegal};
`ifdef EXEC_MFC_TIMEOUT_EN
  assign anyOut = anyCore | memErr;
`else
  assign anyOut = anyCore;
`endif

  always #5 clk = ~clk;

  exec_fsm dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .MFC(MFC),
    .rdAddr(rdAddr), .rsAddr(rsAddr), .regAout(regAout), .regBout(regBout),
    .aluOp(aluOp), .aluEN(aluEN), .regWrite(regWrite), .immOut(immOut), .immEN(immEN),
    .MARin(MARin), .memEN(memEN), .RW(RW), .MDRreadEN(MDRreadEN), .MDRout(MDRout),
    .MDRin(MDRin), .PCinc(PCinc), .PCload(PCload), .done(done), .busy(busy),
    .halted(halted),
`ifdef EXEC_MFC_TIMEOUT_EN
    .memErr(memErr),
`endif
    .illegal(illegal)
  );

  // Start-to-done latency in cycles; n is the number of MWAIT cycles without MFC; -1 means never.
  function automatic int expLatency(input logic [3:0] op, input int n);
    if (op == 4'h0 || op == 4'h8 || (op >= 4'h9 && op <= 4'hE)) return 3;
    if (op >= 4'h1 && op <= 4'h4) return 5;
    if (op == 4'h5) return 7 + n;
    if (op == 4'h6) return 6 + n;
    if (op == 4'h7) return 4;
    return -1;
  endfunction

  // Issues one instruction, raises MFC after n miss cycles, and records what every strobe did per cycle.
  task automatic applyStimulus(input logic [15:0] instr, input int n, input int budget);
    int c;
    logic [15:0] expImm;
    logic isMemOp;
    expImm  = {10'b0, instr[5:0]};
    isMemOp = (instr[15:12] == 4'h5) || (instr[15:12] == 4'h6);
    oDone = -1; oRegWAt = -1; oPcIncAt = -1; oMarAt = -1; oAluAt = -1;
    oMdrInAt = -1; oMdrOutAt = -1; oAluOp = 3'd0;
    oDoneCnt = 0; oRegW = 0; oPcInc = 0; oPcLoad = 0; oMem = 0; oRw = 0; oMar = 0;
    oAlu = 0; oRegA = 0; oRegB = 0; oMdrIn = 0; oMdrOut = 0; oMdrRd = 0; oImm = 0;
    oBusy = 0; oFieldErr = 0;
    start = 1'b1;
    ir    = instr;
    MFC   = 1'($urandom_range(0, 1));
    c = 0;
    while (oDone < 0 && c < budget) begin
      @(negedge clk);
      c++;
      if (rdAddr !== instr[11:9] || rsAddr !== instr[8:6] || immOut !== expImm) oFieldErr++;
      if (done)     begin oDoneCnt++; if (oDone < 0) oDone = c; end
      if (regWrite) begin oRegW++; if (oRegWAt < 0) oRegWAt = c; end
      if (PCinc)    begin oPcInc++; if (oPcIncAt < 0) oPcIncAt = c; end
      if (MARin)    begin oMar++; if (oMarAt < 0) oMarAt = c; end
      if (aluEN)    begin oAlu++; if (oAluAt < 0) oAluAt = c; oAluOp = aluOp; end
      if (MDRin)    begin oMdrIn++; if (oMdrInAt < 0) oMdrInAt = c; end
      if (MDRout)   begin oMdrOut++; if (oMdrOutAt < 0) oMdrOutAt = c; end
      if (PCload)    oPcLoad++;
      if (memEN)     oMem++;
      if (RW)        oRw++;
      if (regAout)   oRegA++;
      if (regBout)   oRegB++;
      if (MDRreadEN) oMdrRd++;
      if (immEN)     oImm++;
      if (busy)      oBusy++;
      start = 1'($urandom_range(0, 1));
      ir    = 16'($urandom);
      MFC   = (isMemOp && c >= 4) ? (c == 4 + n) : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if (done) oDoneCnt++;
    oEndBusy    = busy;
    oEndDone    = done;
    oEndIllegal = illegal;
    oEndHalted  = halted;
`ifdef EXEC_MFC_TIMEOUT_EN
    oEndMemErr  = memErr;
`else
    oEndMemErr  = 1'b0;
`endif
    start = 1'b0;
    ir    = 16'h0000;
    MFC   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; ir = 16'h0000; MFC = 1'b0;
    repeat (3) @(negedge clk);
    if (anyOut !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.outputs got=%b exp=0", anyOut); end
    vectors++;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1; ir = 16'h5080;
    @(negedge clk);
    start = 1'b0; ir = 16'h0000;
    repeat (4) @(negedge clk);
    if (memEN !== 1'b1) begin miscompares++; $display("[TB] FAIL reset.preMwait memEN got=%b exp=1", memEN); end
    vectors++;
    #2 rst = 1'b0;
    #1;
    if (anyOut !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.async got=%b exp=0", anyOut); end
    vectors++;
    repeat (2) @(negedge clk);
    if (anyOut !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.hold got=%b exp=0", anyOut); end
    vectors++;
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0000, 0, 20);
    if (oPcIncAt !== 2) begin miscompares++; $display("[TB] FAIL nop.pcIncAt got=%0d exp=2", oPcIncAt); end
    vectors++;
    if (oDone !== 3) begin miscompares++; $display("[TB] FAIL nop.doneAt got=%0d exp=3", oDone); end
    vectors++;
  endtask

  task automatic test_alu();
    applyStimulus(16'h1280, 0, 20);
    if (oFieldErr !== 0) begin miscompares++; $display("[TB] FAIL add.fields errCycles=%0d exp=0 rd=%0d rs=%0d", oFieldErr, rdAddr, rsAddr); end
    vectors++;
    if (oAluOp !== 3'd1 || oAluAt !== 2) begin miscompares++; $display("[TB] FAIL add.alu op=%0d at=%0d exp op=1 at=2", oAluOp, oAluAt); end
    vectors++;
    if (oRegWAt !== 3 || oPcIncAt !== 4 || oDone !== 5) begin
      miscompares++; $display("[TB] FAIL add.timing regW=%0d pcInc=%0d done=%0d exp 3/4/5", oRegWAt, oPcIncAt, oDone);
    end
    vectors++;
  endtask

  task automatic test_load();
    applyStimulus(16'h5080, 3, 30);
    if (oMarAt !== 2 || oMem !== 5 || oRw !== 5) begin
      miscompares++; $display("[TB] FAIL load.mem marAt=%0d memCyc=%0d rwCyc=%0d exp 2/5/5", oMarAt, oMem, oRw);
    end
    vectors++;
    if (oMdrOutAt !== 8 || oRegWAt !== 8 || oDone !== 10) begin
      miscompares++; $display("[TB] FAIL load.timing mdrOut=%0d regW=%0d done=%0d exp 8/8/10", oMdrOutAt, oRegWAt, oDone);
    end
    vectors++;
  endtask

  task automatic test_store();
    applyStimulus(16'h6140, 0, 30);
    if (oRw !== 0 || oMdrInAt !== 3 || oRegW !== 0 || oMem !== 2) begin
      miscompares++; $display("[TB] FAIL store.strobes rw=%0d mdrInAt=%0d regW=%0d mem=%0d exp 0/3/0/2", oRw, oMdrInAt, oRegW, oMem);
    end
    vectors++;
    if (oDone !== 6) begin miscompares++; $display("[TB] FAIL store.doneAt got=%0d exp=6", oDone); end
    vectors++;
  endtask

  task automatic test_jump_illegal();
    applyStimulus(16'h802A, 0, 20);
    if (oFieldErr !== 0 || oPcLoad !== 1 || oPcInc !== 0 || oDone !== 3) begin
      miscompares++; $display("[TB] FAIL jmp fieldErr=%0d pcLoad=%0d pcInc=%0d done=%0d exp 0/1/0/3", oFieldErr, oPcLoad, oPcInc, oDone);
    end
    vectors++;
    if (oEndIllegal !== 1'b0) begin miscompares++; $display("[TB] FAIL jmp.illegal got=%b exp=0", oEndIllegal); end
    vectors++;
    applyStimulus(16'hA000, 0, 20);
    stickyIllegal = 1'b1;
    if (oEndIllegal !== 1'b1 || oDone !== 3) begin
      miscompares++; $display("[TB] FAIL illegal.set illegal=%b done=%0d exp 1/3", oEndIllegal, oDone);
    end
    vectors++;
    applyStimulus(16'h0000, 0, 20);
    if (oEndIllegal !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal.sticky got=%b exp=1", oEndIllegal); end
    vectors++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [3:0] op;
      logic [15:0] instr;
      int n, L;
      bit isAlu, isLd, isSt, isLdi, isJmp, isIll, isMemOp;
      int eRegW, ePcInc, eMem;
      op    = 4'($urandom_range(0, 14));
      instr = {op, 12'($urandom)};
      n     = $urandom_range(0, 5);
      isAlu = (op >= 4'h1 && op <= 4'h4);
      isLd  = (op == 4'h5);
      isSt  = (op == 4'h6);
      isLdi = (op == 4'h7);
      isJmp = (op == 4'h8);
      isIll = (op >= 4'h9 && op <= 4'hE);
      isMemOp = isLd || isSt;
      L      = expLatency(op, n);
      eRegW  = (isAlu || isLdi || isLd) ? 1 : 0;
      ePcInc = isJmp ? 0 : 1;
      eMem   = isMemOp ? n + 2 : 0;
      if (isIll) stickyIllegal = 1'b1;
      applyStimulus(instr, n, L + 10);
      if (oDone !== L) begin miscompares++; $display("[TB] FAIL rand.doneAt ir=%h n=%0d got=%0d exp=%0d", instr, n, oDone, L); end
      vectors++;
      if (oDoneCnt !== 1 || oEndDone !== 1'b0 || oEndBusy !== 1'b0) begin
        miscompares++; $display("[TB] FAIL rand.donePulse ir=%h cnt=%0d endDone=%b endBusy=%b exp 1/0/0", instr, oDoneCnt, oEndDone, oEndBusy);
      end
      vectors++;
      if (oBusy !== L) begin miscompares++; $display("[TB] FAIL rand.busy ir=%h got=%0d exp=%0d", instr, oBusy, L); end
      vectors++;
      if (oRegW !== eRegW) begin miscompares++; $display("[TB] FAIL rand.regW ir=%h got=%0d exp=%0d", instr, oRegW, eRegW); end
      vectors++;
      if (eRegW == 1) begin
        if (oRegWAt !== L - 2) begin miscompares++; $display("[TB] FAIL rand.regWAt ir=%h got=%0d exp=%0d", instr, oRegWAt, L - 2); end
        vectors++;
      end
      if (oPcInc !== ePcInc || oPcLoad !== int'(isJmp)) begin
        miscompares++; $display("[TB] FAIL rand.pc ir=%h inc=%0d load=%0d exp %0d/%0d", instr, oPcInc, oPcLoad, ePcInc, isJmp);
      end
      vectors++;
      if (ePcInc == 1) begin
        if (oPcIncAt !== L - 1) begin miscompares++; $display("[TB] FAIL rand.pcIncAt ir=%h got=%0d exp=%0d", instr, oPcIncAt, L - 1); end
        vectors++;
      end
      if (oMem !== eMem || oRw !== (isLd ? eMem : 0) || oMar !== int'(isMemOp)) begin
        miscompares++; $display("[TB] FAIL rand.mem ir=%h memEN=%0d RW=%0d MARin=%0d exp %0d/%0d/%0d", instr, oMem, oRw, oMar, eMem, isLd ? eMem : 0, isMemOp);
      end
      vectors++;
      if (oAlu !== int'(isAlu) || (isAlu && oAluOp !== op[2:0])) begin
        miscompares++; $display("[TB] FAIL rand.alu ir=%h aluEN=%0d aluOp=%0d exp %0d/%0d", instr, oAlu, oAluOp, isAlu, op[2:0]);
      end
      vectors++;
      if (oRegA !== int'(isAlu || isMemOp) || oRegB !== int'(isAlu || isSt)) begin
        miscompares++; $display("[TB] FAIL rand.regOut ir=%h A=%0d B=%0d exp %0d/%0d", instr, oRegA, oRegB, isAlu || isMemOp, isAlu || isSt);
      end
      vectors++;
      if (oMdrIn !== int'(isSt) || oMdrOut !== int'(isLd) || oMdrRd !== int'(isLd) || oImm !== int'(isLdi || isJmp)) begin
        miscompares++; $display("[TB] FAIL rand.mdrImm ir=%h in=%0d out=%0d rd=%0d imm=%0d", instr, oMdrIn, oMdrOut, oMdrRd, oImm);
      end
      vectors++;
      if (oFieldErr !== 0) begin miscompares++; $display("[TB] FAIL rand.fields ir=%h errCycles=%0d exp=0", instr, oFieldErr); end
      vectors++;
      if (oEndIllegal !== stickyIllegal) begin miscompares++; $display("[TB] FAIL rand.illegal ir=%h got=%b exp=%b", instr, oEndIllegal, stickyIllegal); end
      vectors++;
    end
  endtask

`ifdef EXEC_MFC_TIMEOUT_EN
  task automatic test_timeout();
    applyStimulus(16'h5080, 1000, 40);
    if (oDone !== 20 || oMem !== 16 || oRegW !== 0 || oMdrOut !== 0) begin
      miscompares++; $display("[TB] FAIL timeout done=%0d mem=%0d regW=%0d mdrOut=%0d exp 20/16/0/0", oDone, oMem, oRegW, oMdrOut);
    end
    vectors++;
    if (oEndMemErr !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout.memErr got=%b exp=1", oEndMemErr); end
    vectors++;
    applyStimulus(16'h5080, 2, 30);
    if (oDone !== 9 || oEndMemErr !== 1'b1) begin
      miscompares++; $display("[TB] FAIL timeout.sticky done=%0d memErr=%b exp 9/1", oDone, oEndMemErr);
    end
    vectors++;
  endtask
`else
  task automatic test_long_wait();
    applyStimulus(16'h5080, 20, 60);
    if (oDone !== 27 || oMem !== 22 || oRegWAt !== 25) begin
      miscompares++; $display("[TB] FAIL longWait done=%0d mem=%0d regWAt=%0d exp 27/22/25", oDone, oMem, oRegWAt);
    end
    vectors++;
  endtask
`endif

  task automatic test_halt();
    int pcSeen;
    applyStimulus(16'hF000, 0, 12);
    if (oDoneCnt !== 0 || oEndHalted !== 1'b1 || oEndBusy !== 1'b0 || oBusy !== 1) begin
      miscompares++; $display("[TB] FAIL halt done=%0d halted=%b busyEnd=%b busyCyc=%0d exp 0/1/0/1", oDoneCnt, oEndHalted, oEndBusy, oBusy);
    end
    vectors++;
    pcSeen = 0;
    start = 1'b1; ir = 16'h0000;
    repeat (6) begin
      @(negedge clk);
      if (PCinc || busy || done || !halted) pcSeen++;
    end
    start = 1'b0;
    if (pcSeen !== 0) begin miscompares++; $display("[TB] FAIL halt.startIgnored activeCycles=%0d exp=0", pcSeen); end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jump_illegal();
    test_random();
`ifdef EXEC_MFC_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_fsm.md
Name: exec_fsm

Overview:
- Execute-stage controller of the microcontroller, directly downstream of the instruction-fetch FSM.
- Captures the instruction word when fetch pulses IRin (start).
- Sequences register/ALU, load/store (MAR/MDR with MFC handshake) and PC-update control strobes.
- Pulses done for one cycle to re-launch fetch.

Parameters:
- DATAW, 16, instruction/data word width
- REGAW, 3, register-file address width
- OPW, 4, opcode field width (ir[DATAW-1 -: OPW])

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  IRin pulse from fetch; ir is valid on the same cycle
- ir  in  DATAW  instruction word
- MFC  in  1  memory function complete
- rdAddr  out  REGAW  destination register (ir[11:9])
- rsAddr  out  REGAW  source register (ir[8:6])
- regAout, regBout  out  1 each  register file drives ALU A/B operands
- aluOp  out  3  0 pass, 1 add, 2 sub, 3 and, 4 or
- aluEN  out  1  ALU result latch enable
- regWrite  out  1  write result/bus to rdAddr
- immOut  out  DATAW  zero-extended ir[5:0]
- immEN  out  1  immOut drives bus
- MARin, memEN, RW, MDRreadEN, MDRout, MDRin  out  1 each  memory strobes; RW=1 read, 0 write
- PCinc, PCload  out  1 each  PC increment / load from bus
- done  out  1  one-cycle restart pulse to fetch
- busy  out  1  high whenever state != IDLE/HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky, set by undefined opcode; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, instruction register cleared, every output 0, illegal=0.
- Outputs are registered Moore outputs, decoded from state and the latched instruction.
- IDLE: when start=1, latch ir and go to DECODE; otherwise hold.
- DECODE: one cycle; branch on opcode.
  - 1-4 (ADD/SUB/AND/OR) -> ALU
  - 5 (LOAD), 6 (STORE) -> MADDR
  - 7 (LDI) -> WB_IMM
  - 8 (JMP) -> JUMP
  - 0 (NOP) -> PCINC
  - F (HALT) -> HALT
  - any other opcode: set illegal, -> PCINC
- ALU: regAout=1, regBout=1, aluEN=1, aluOp per opcode; -> WB.
- WB: regWrite=1; -> PCINC.
- WB_IMM: immEN=1, regWrite=1; -> PCINC.
- MADDR: regAout=1 (rs is the address), MARin=1; -> MREQ.
- MREQ:
  - LOAD: memEN=1, RW=1.
  - STORE: regBout=1, MDRin=1, memEN=1, RW=0.
  - -> MWAIT.
- MWAIT: memEN held, RW held. Stay until MFC=1. MFC is sampled only here; MFC in any other state is ignored.
  - On MFC: LOAD -> MDATA, STORE -> PCINC.
- MDATA: MDRreadEN=1, MDRout=1, regWrite=1; -> PCINC.
- JUMP: immEN=1, PCload=1; -> DONE. PC is not incremented.
- PCINC: PCinc=1; -> DONE.
- DONE: done=1 for exactly one cycle; -> IDLE.
- HALT: halted=1, terminal; only reset exits.
- start while busy is ignored; the instruction register is not overwritten.
- Latency, start to done:
  - NOP: 3 cycles
  - ALU ops: 5 cycles
  - LDI: 4 cycles
  - JMP: 3 cycles
  - LOAD: 7 + N cycles, where N is the number of MWAIT cycles with MFC=0
  - STORE: 6 + N cycles
- Reset mid-operation: immediate return to IDLE; no done pulse is generated.

Optional Feature:
- Macro: EXEC_MFC_TIMEOUT_EN.
- Defined:
  - Adds a 4-bit watchdog counter, cleared on entry to MWAIT and incremented each MWAIT cycle with MFC=0.
  - On the 15th consecutive miss: assert memErr (extra output, sticky until reset), drop memEN, go to PCINC; a LOAD writes nothing.
- Undefined: no counter, no memErr port; MWAIT waits for MFC indefinitely.

Decomposition:
- Package exec_pkg: opcode localparams (OP_NOP..OP_HALT), state encoding (4-bit), aluOp codes, field bit-position constants.
- One natural sub-module, exec_decode: combinational opcode classifier producing isAlu, isMem, isLoad, isImm, isJump, isHalt, isIllegal and aluOp.

Test Plan:
- Reset: rst low mid-MWAIT -> all outputs 0, state IDLE; after release, start with ir=0x0000 -> PCinc at cycle 2, done pulse at cycle 3.
- ADD: ir=0x1280 -> rdAddr=1, rsAddr=2, aluOp=1; aluEN asserted 2 cycles after start, regWrite 3 cycles after, then PCinc, then done.
- LOAD with MFC after 3 wait cycles: ir=0x5080 -> MARin, then memEN/RW=1 held through MWAIT; MDRout and regWrite one cycle after MFC; done at cycle 10.
- STORE with immediate MFC -> RW=0 and MDRin during MREQ; no regWrite; done at cycle 6.
- JMP ir=0x802A -> immOut=0x002A, PCload=1, PCinc never asserted, done at cycle 3; illegal opcode 0xA000 -> illegal=1 and stays set over the next instruction.
- HALT ir=0xF000 -> halted=1, done never pulses, start ignored. With EXEC_MFC_TIMEOUT_EN: LOAD with MFC held low -> memErr after 15 MWAIT cycles, then done.
